// File: rtl/cycle_counter.sv
// cycle_counter: free-running 64-bit cycle counter for the pipelined CPU.
// Counts every rising clock edge while the core is not halted; a
// synchronous clear has priority over halt and increment. A sticky wrap
// flag records overflow of the full 64-bit count.
// Optional feature macro: CYCLE_COUNTER_SNAPSHOT_EN adds a snapshot
// request input (snap) and a 64-bit capture register (snap_count).
module cycle_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        clr,
  output logic [31:0] count,
  output logic [31:0] count_hi,
  output logic        wrap
`ifdef CYCLE_COUNTER_SNAPSHOT_EN
  ,
  input  logic        snap,
  output logic [63:0] snap_count
`endif
);

  logic [63:0] r_cnt;
  logic        r_wrap;
  logic [63:0] w_next_cnt;
  logic        w_next_wrap;
  logic        w_at_max;

  // Terminal-count detect: an increment from here wraps to zero
  assign w_at_max = (r_cnt == {64{1'b1}});

  // Next-state selection: clear beats halt, halt beats increment
  always_comb begin
    w_next_cnt  = r_cnt;
    w_next_wrap = r_wrap;
    if (clr) begin
      w_next_cnt  = 64'd0;
      w_next_wrap = 1'b0;
    end else if (halt) begin
      w_next_cnt  = r_cnt;
      w_next_wrap = r_wrap;
    end else begin
      // Single 64-bit add keeps low/high words coherent (no torn value)
      w_next_cnt  = r_cnt + 64'd1;
      w_next_wrap = r_wrap | w_at_max;
    end
  end

  // Count and sticky wrap registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= 64'd0;
      r_wrap <= 1'b0;
    end else begin
      r_cnt  <= w_next_cnt;
      r_wrap <= w_next_wrap;
    end
  end

  // Outputs come straight from registers, independent of halt/clr/snap
  assign count    = r_cnt[31:0];
  assign count_hi = r_cnt[63:32];
  assign wrap     = r_wrap;

`ifdef CYCLE_COUNTER_SNAPSHOT_EN
  logic [63:0] r_snap_count;

  // Capture the pre-update count on request, regardless of halt or clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap_count <= 64'd0;
    end else if (snap) begin
      r_snap_count <= r_cnt;
    end else begin
      r_snap_count <= r_snap_count;
    end
  end

  assign snap_count = r_snap_count;
`endif

endmodule

// File: tb/tb_cycle_counter.sv
// Directed self-checking bench for cycle_counter.
module tb_cycle_counter;

  logic        clk;
  logic        rst;
  logic        halt;
  logic        clr;
  logic [31:0] count;
  logic [31:0] count_hi;
  logic        wrap;
`ifdef CYCLE_COUNTER_SNAPSHOT_EN
  logic        snap;
  logic [63:0] snap_count;
`endif

  int total;
  int bad;

  cycle_counter dut (
    .clk      (clk),
    .rst      (rst),
    .halt     (halt),
    .clr      (clr),
    .count    (count),
    .count_hi (count_hi),
    .wrap     (wrap)
`ifdef CYCLE_COUNTER_SNAPSHOT_EN
    ,
    .snap       (snap),
    .snap_count (snap_count)
`endif
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle on the following falling edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    halt  = 1'b0;
    clr   = 1'b0;
`ifdef CYCLE_COUNTER_SNAPSHOT_EN
    snap  = 1'b0;
`endif

    // Reset state
    tick(2);
    chk("rst_count",    {32'd0, count},    64'd0);
    chk("rst_count_hi", {32'd0, count_hi}, 64'd0);
    chk("rst_wrap",     {63'd0, wrap},     64'd0);
`ifdef CYCLE_COUNTER_SNAPSHOT_EN
    chk("rst_snap", snap_count, 64'd0);
`endif

    // First edge after release gives 1; ten edges give 10
    rst = 1'b0;
    tick(1);
    chk("first_edge", {32'd0, count}, 64'd1);
    tick(9);
    chk("ten_count",    {32'd0, count},    64'd10);
    chk("ten_count_hi", {32'd0, count_hi}, 64'd0);
    chk("ten_wrap",     {63'd0, wrap},     64'd0);

    // Count to 5, halt for 20 edges, resume for 3
    clr = 1'b1;
    tick(1);
    chk("clr_basic", {32'd0, count}, 64'd0);
    clr = 1'b0;
    tick(5);
    chk("pre_halt", {32'd0, count}, 64'd5);
    halt = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("halt_hold", {32'd0, count}, 64'd5);
    end
    halt = 1'b0;
    tick(3);
    chk("resume", {32'd0, count}, 64'd8);

    // Asynchronous reset between edges at count 37
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(37);
    chk("pre_async", {32'd0, count}, 64'd37);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", {32'd0, count}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    chk("restart", {32'd0, count}, 64'd1);

    // clr together with halt at count 100
    tick(99);
    chk("pre_clr", {32'd0, count}, 64'd100);
    clr  = 1'b1;
    halt = 1'b1;
    tick(1);
    chk("clr_halt", {32'd0, count}, 64'd0);
    clr = 1'b0;
    tick(5);
    chk("clr_halt_hold", {32'd0, count}, 64'd0);
    halt = 1'b0;
    tick(2);
    chk("after_clr_halt", {32'd0, count}, 64'd2);

    // Low-word carry into high word
    force dut.r_cnt = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.r_cnt;
    tick(1);
    chk("carry_lo",   {32'd0, count},    64'd0);
    chk("carry_hi",   {32'd0, count_hi}, 64'd1);
    chk("carry_wrap", {63'd0, wrap},     64'd0);

    // Full 64-bit wrap and sticky flag
    force dut.r_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.r_cnt;
    tick(1);
    chk("wrap_lo",   {32'd0, count},    64'd0);
    chk("wrap_hi",   {32'd0, count_hi}, 64'd0);
    chk("wrap_flag", {63'd0, wrap},     64'd1);
    tick(3);
    chk("wrap_sticky", {63'd0, wrap},  64'd1);
    chk("wrap_cont",   {32'd0, count}, 64'd3);
    halt = 1'b1;
    tick(2);
    chk("wrap_halt_hold", {63'd0, wrap}, 64'd1);
    halt = 1'b0;
    clr  = 1'b1;
    tick(1);
    chk("wrap_clr", {63'd0, wrap}, 64'd0);
    clr = 1'b0;

`ifdef CYCLE_COUNTER_SNAPSHOT_EN
    // Snapshot at cnt = 42, then held while counting continues
    tick(42);
    chk("pre_snap", {32'd0, count}, 64'd42);
    snap = 1'b1;
    tick(1);
    snap = 1'b0;
    chk("snap_val",  snap_count, 64'd42);
    chk("snap_next", {32'd0, count}, 64'd43);
    tick(5);
    chk("snap_hold", snap_count, 64'd42);
    chk("snap_adv",  {32'd0, count}, 64'd48);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
